// File: rtl/pkt_pkg.sv
// pkt_pkg: definitions shared by the packetizer and the flit depacketizer.
//   - flit_type codes carried alongside every flit
//   - head/tail marker constants
//   - bit positions of every field in the 256-bit flit
//   - transmit FSM state encoding
package pkt_pkg;

  localparam int unsigned FLIT_W = 256;

  // flit_type codes
  localparam logic [1:0] FT_NONE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  localparam logic [7:0]  HEAD_MARKER = 8'hA5;
  localparam logic [15:0] TAIL_MARKER = 16'hFFFF;

  // Head flit fields (LSB positions)
  localparam int unsigned HF_MARK_LSB = 248;
  localparam int unsigned HF_DEST_LSB = 240;
  localparam int unsigned HF_SRC_LSB  = 232;
  localparam int unsigned HF_SEQ_LSB  = 224;

  // Body flit fields
  localparam int unsigned BF_DATA_LSB = 240;
  localparam int unsigned BF_SEQ_LSB  = 232;

  // Tail flit fields
  localparam int unsigned TF_SEQ_LSB  = 224;
  localparam int unsigned TF_CHK_LSB  = 16;
  localparam int unsigned TF_MARK_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    TAIL = 2'b11
  } state_e;

  // flit_type reported while the FSM sits in a given state
  function automatic logic [1:0] flit_type_of(input state_e s);
    logic [1:0] t;
    unique case (s)
      HEAD:    t = FT_HEAD;
      BODY:    t = FT_BODY;
      TAIL:    t = FT_TAIL;
      default: t = FT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/packetizer_flit_fmt.sv
// packetizer_flit_fmt: purely combinational flit formatter.
// Builds the 256-bit flit that corresponds to the given FSM state.
//   state  : state whose flit is to be built (IDLE yields all zeros)
//   word   : captured payload word
//   dest   : captured destination identifier
//   src_id : source identifier placed in the head flit
//   seq    : packet sequence number
//   flit   : formatted flit
// Build option: define PACKETIZER_CHECK_EN to place the inverted payload
// word in the tail flit check field; otherwise that field is zero.
module packetizer_flit_fmt
  import pkt_pkg::*;
(
  input  state_e        state,
  input  logic [15:0]   word,
  input  logic [7:0]    dest,
  input  logic [7:0]    src_id,
  input  logic [7:0]    seq,
  output logic [255:0]  flit
);

  always_comb begin
    flit = '0;
    unique case (state)
      HEAD: begin
        flit[HF_MARK_LSB +: 8] = HEAD_MARKER;
        flit[HF_DEST_LSB +: 8] = dest;
        flit[HF_SRC_LSB  +: 8] = src_id;
        flit[HF_SEQ_LSB  +: 8] = seq;
      end
      BODY: begin
        flit[BF_DATA_LSB +: 16] = word;
        flit[BF_SEQ_LSB  +: 8]  = seq;
      end
      TAIL: begin
        flit[TF_MARK_LSB +: 16] = TAIL_MARKER;
`ifdef PACKETIZER_CHECK_EN
        flit[TF_CHK_LSB  +: 16] = ~word;
`endif
        flit[TF_SEQ_LSB  +: 8]  = seq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/packetizer.sv
// packetizer: wraps each accepted 16-bit word into a head/body/tail packet
// and emits the flits one per handshake on a 256-bit stream.
//   clk, reset  : clock, asynchronous active-high reset
//   data_in     : payload word          dest_id : destination identifier
//   data_valid  : word valid            data_ready : word can be accepted
//   flit_out    : current flit          flit_type  : 00 none/01 head/10 body/11 tail
//   flit_valid  : flit_out valid        flit_ready : downstream accepts flit
//   pkt_done    : one-cycle pulse after the tail flit is accepted
// Parameter SRC_ID: source identifier inserted into every head flit.
// Build option PACKETIZER_CHECK_EN (see packetizer_flit_fmt) fills the tail
// check word with the inverted payload.
module packetizer
  import pkt_pkg::*;
#(
  parameter logic [7:0] SRC_ID = 8'h01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  data_in,
  input  logic [7:0]   dest_id,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [255:0] flit_out,
  output logic [1:0]   flit_type,
  output logic         flit_valid,
  input  logic         flit_ready,
  output logic         pkt_done
);

  state_e       state;
  state_e       state_nxt;
  logic [15:0]  word_q;
  logic [7:0]   dest_q;
  logic [7:0]   seq_q;

  logic         accept;
  logic         xfer;
  logic         tail_xfer;
  logic [15:0]  word_nxt;
  logic [7:0]   dest_nxt;
  logic [7:0]   seq_nxt;
  logic [255:0] flit_nxt;

  // Only combinational path from flit_ready to an output.
  assign data_ready = !reset && ((state == IDLE) || ((state == TAIL) && flit_ready));
  assign accept     = data_valid && data_ready;
  assign xfer       = flit_valid && flit_ready;
  assign tail_xfer  = (state == TAIL) && xfer;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = HEAD;
      HEAD: if (xfer)   state_nxt = BODY;
      BODY: if (xfer)   state_nxt = TAIL;
      TAIL: if (xfer)   state_nxt = accept ? HEAD : IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // The formatter sees next-cycle values so the flit can be registered
  // together with the state: a freshly accepted word and the sequence
  // number bumped by a tail transfer are already visible to the new head.
  assign word_nxt = accept ? data_in : word_q;
  assign dest_nxt = accept ? dest_id : dest_q;
  assign seq_nxt  = seq_q + {7'd0, tail_xfer};

  packetizer_flit_fmt u_flit_fmt (
    .state  (state_nxt),
    .word   (word_nxt),
    .dest   (dest_nxt),
    .src_id (SRC_ID),
    .seq    (seq_nxt),
    .flit   (flit_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_q     <= '0;
      dest_q     <= '0;
      seq_q      <= '0;
      flit_out   <= '0;
      flit_type  <= FT_NONE;
      flit_valid <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_q      <= seq_nxt;
      if (accept) begin
        word_q <= data_in;
        dest_q <= dest_id;
      end
      flit_valid <= (state_nxt != IDLE);
      flit_type  <= flit_type_of(state_nxt);
      // Last flit stays on the bus while idle.
      if (state_nxt != IDLE) flit_out <= flit_nxt;
      pkt_done   <= tail_xfer;
    end
  end

endmodule
